// File: rtl/decode_queue_ooo_if.sv
// rtl/decode_queue_ooo_if.sv - fetch-side and dispatch-side handshake bundle for the decode queue
interface decode_queue_ooo_if #(
    parameter int PC_W   = 64,
    parameter int SEQ_W  = 6,
    parameter int MAX_BR = 4
);
    localparam int BRW = $clog2(MAX_BR + 1);

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [PC_W-1:0]  in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [PC_W-1:0]  out_pc;
    logic [SEQ_W-1:0] out_seq;
    logic [4:0]       out_rd;
    logic [4:0]       out_rn;
    logic [4:0]       out_rm;
    logic [25:0]      out_imm;
    logic [3:0]       out_cmd_type;
    logic [2:0]       out_alu_op;
    logic [1:0]       out_which_math;
    logic [7:0]       out_ctrl;
    logic [BRW-1:0]   br_count;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_seq, out_rd, out_rn, out_rm, out_imm,
        input  out_cmd_type, out_alu_op, out_which_math, out_ctrl, br_count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_seq, out_rd, out_rn, out_rm, out_imm,
        output out_cmd_type, out_alu_op, out_which_math, out_ctrl, br_count
    );
endinterface

// File: rtl/decode_queue_ooo.sv
// rtl/decode_queue_ooo.sv - LEGv8 decoder feeding a DEPTH-entry micro-op FIFO with branch cap and flush
module decode_queue_ooo #(
    parameter int DEPTH  = 8,
    parameter int PC_W   = 64,
    parameter int SEQ_W  = 6,
    parameter int MAX_BR = 4
) (
    input logic               clk,
    input logic               reset_n,
    decode_queue_ooo_if.slave q
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int BRW = $clog2(MAX_BR + 1);

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [SEQ_W-1:0] seq;
        logic [4:0]       rd;
        logic [4:0]       rn;
        logic [4:0]       rm;
        logic [25:0]      imm;
        logic [3:0]       cmd_type;
        logic [2:0]       alu_op;
        logic [1:0]       which_math;
        logic [7:0]       ctrl;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           dec;
    entry_t           head_e;
    entry_t           out_e;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [SEQ_W-1:0] seq_ctr;
    logic [BRW-1:0]   br_cnt;
    logic             push;
    logic             pop;
    logic             push_br;
    logic             pop_br;

    // ctrl = {reg_write, mem_write, mem_to_reg, alu_src, save_cond, left_shift, is_branch, illegal}
    always_comb begin
        dec     = '0;
        dec.pc  = q.in_pc;
        dec.seq = seq_ctr;
        dec.rd  = q.in_instr[4:0];
        dec.rn  = q.in_instr[9:5];
        dec.rm  = q.in_instr[20:16];
        dec.imm = q.in_instr[25:0];
        casez (q.in_instr[31:21])
            11'b1001000100?: begin dec.alu_op = 3'd2; dec.ctrl = 8'b1001_0000; end
            11'b10001011000: begin dec.alu_op = 3'd2; dec.ctrl = 8'b1000_0000; end
            11'b10101011000: begin dec.alu_op = 3'd2; dec.ctrl = 8'b1000_1000; end
            11'b11001011000: begin dec.alu_op = 3'd3; dec.ctrl = 8'b1000_0000; end
            11'b11101011000: begin dec.alu_op = 3'd3; dec.ctrl = 8'b1000_1000; end
            11'b10001010000: begin dec.alu_op = 3'd4; dec.ctrl = 8'b1000_0000; end
            11'b10101010000: begin dec.alu_op = 3'd5; dec.ctrl = 8'b1000_0000; end
            11'b11001010000: begin dec.alu_op = 3'd6; dec.ctrl = 8'b1000_0000; end
            11'b11010011010: begin dec.which_math = 2'd1; dec.ctrl = 8'b1000_0000; end
            11'b11010011011: begin dec.which_math = 2'd1; dec.ctrl = 8'b1000_0100; end
            11'b10011011000: begin dec.which_math = 2'd2; dec.ctrl = 8'b1000_0000; end
            11'b10011010110: begin dec.which_math = 2'd3; dec.ctrl = 8'b1000_0000; end
            11'b11111000010: begin dec.alu_op = 3'd2; dec.ctrl = 8'b1011_0000; end
            11'b11111000000: begin dec.alu_op = 3'd2; dec.cmd_type = 4'd1; dec.ctrl = 8'b0101_0000; end
            11'b000101?????: begin dec.cmd_type = 4'd8; dec.ctrl = 8'b0000_0010; end
            11'b100101?????: begin dec.cmd_type = 4'd7; dec.ctrl = 8'b1000_0010; dec.rd = 5'd30; end
            11'b10110100???: begin dec.cmd_type = 4'd5; dec.ctrl = 8'b0000_0010; end
            11'b01010100???: begin dec.cmd_type = 4'd3; dec.ctrl = 8'b0000_0010; end
            11'b11010110000: begin dec.cmd_type = 4'd6; dec.ctrl = 8'b0000_0010; end
            default:         dec.ctrl = 8'b0000_0001;
        endcase
    end

    assign head_e     = mem[head];
    assign q.out_valid = (count != '0);
    assign q.in_ready  = (count < CW'(DEPTH)) & ~(dec.ctrl[1] & (br_cnt == BRW'(MAX_BR)));

    assign push    = q.in_valid & q.in_ready & ~q.flush;
    assign pop     = q.out_valid & q.out_ready & ~q.flush;
    assign push_br = push & dec.ctrl[1];
    assign pop_br  = pop & head_e.ctrl[1];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= dec;
        end
    end

    // seq_ctr survives flush so tags stay monotonic for rename
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            seq_ctr <= '0;
            br_cnt  <= '0;
        end else if (q.flush) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            br_cnt <= '0;
        end else begin
            if (push) begin
                tail    <= tail + PW'(1);
                seq_ctr <= seq_ctr + SEQ_W'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count  <= count + CW'(push) - CW'(pop);
            br_cnt <= br_cnt + BRW'(push_br) - BRW'(pop_br);
        end
    end

    assign out_e            = q.out_valid ? head_e : '0;
    assign q.out_pc         = out_e.pc;
    assign q.out_seq        = out_e.seq;
    assign q.out_rd         = out_e.rd;
    assign q.out_rn         = out_e.rn;
    assign q.out_rm         = out_e.rm;
    assign q.out_imm        = out_e.imm;
    assign q.out_cmd_type   = out_e.cmd_type;
    assign q.out_alu_op     = out_e.alu_op;
    assign q.out_which_math = out_e.which_math;
    assign q.out_ctrl       = out_e.ctrl;
    assign q.br_count       = br_cnt;
endmodule

// File: tb/tb_decode_queue_ooo.sv
// tb/tb_decode_queue_ooo.sv - scoreboard bench for decode_queue_ooo
module tb_decode_queue_ooo;
    typedef struct {
        logic [31:0] instr;
        logic [3:0]  cmd;
        logic [2:0]  alu;
        logic [1:0]  wm;
        logic [7:0]  ctrl;
        bit          bl;
    } kind_t;

    localparam int K_ADDI = 0, K_ADD = 1, K_LSL = 9, K_DIV = 11, K_LDUR = 12, K_STUR = 13;
    localparam int K_B = 14, K_BL = 15, K_CBZ = 16, K_ILL = 19, NK = 20;

    logic clk = 1'b0;
    logic reset_n;
    kind_t kt [NK];
    logic [127:0] sb [$];
    int n_chk = 0;
    int n_err = 0;
    int m_br = 0;
    logic [5:0]  m_seq = '0;
    logic [63:0] pc_next = 64'h1000;

    decode_queue_ooo_if #(.PC_W(64), .SEQ_W(6), .MAX_BR(4)) dq ();

    decode_queue_ooo #(.DEPTH(8), .PC_W(64), .SEQ_W(6), .MAX_BR(4)) dut (
        .clk(clk), .reset_n(reset_n), .q(dq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic kind_t mk(input logic [31:0] i, input logic [3:0] c, input logic [2:0] a,
                                 input logic [1:0] w, input logic [7:0] ct, input bit bl);
        kind_t k;
        k.instr = i; k.cmd = c; k.alu = a; k.wm = w; k.ctrl = ct; k.bl = bl;
        return k;
    endfunction

    function automatic logic [127:0] mkrec(input int k, input logic [63:0] pc, input logic [5:0] seq);
        logic [31:0] i;
        logic [4:0]  rd;
        i  = kt[k].instr;
        rd = kt[k].bl ? 5'd30 : i[4:0];
        return {pc, seq, rd, i[9:5], i[20:16], i[25:0], kt[k].cmd, kt[k].alu, kt[k].wm, kt[k].ctrl};
    endfunction

    task automatic step(input int k, input bit v, input bit fl, input bit ordy, output bit acc);
        logic [127:0] rec;
        logic [127:0] exp_head;
        bit rdy, psh, pp;
        dq.in_valid  = v;
        dq.in_instr  = kt[k].instr;
        dq.in_pc     = pc_next;
        dq.flush     = fl;
        dq.out_ready = ordy;
        #2;
        rdy = (sb.size() < 8) && !(kt[k].ctrl[1] && m_br == 4);
        chk("in_ready", 128'(dq.in_ready), 128'(rdy));
        chk("out_valid", 128'(dq.out_valid), 128'(sb.size() != 0));
        chk("br_count", 128'(dq.br_count), 128'(m_br));
        exp_head = (sb.size() != 0) ? sb[0] : '0;
        chk("head", {dq.out_pc, dq.out_seq, dq.out_rd, dq.out_rn, dq.out_rm, dq.out_imm,
                     dq.out_cmd_type, dq.out_alu_op, dq.out_which_math, dq.out_ctrl}, exp_head);
        psh = v && rdy && !fl;
        pp  = (sb.size() != 0) && ordy && !fl;
        rec = mkrec(k, pc_next, m_seq);
        @(posedge clk);
        if (fl) begin
            sb.delete();
            m_br = 0;
        end else begin
            if (pp) begin
                m_br -= int'(sb[0][1]);
                void'(sb.pop_front());
            end
            if (psh) begin
                sb.push_back(rec);
                m_br += int'(kt[k].ctrl[1]);
                m_seq++;
                pc_next += 64'd4;
            end
        end
        acc = psh;
        @(negedge clk);
    endtask

    task automatic drain();
        bit a;
        for (int i = 0; i < 20 && sb.size() != 0; i++) step(K_ADD, 0, 0, 1, a);
        chk("drained", 128'(sb.size()), 128'(0));
    endtask

    task automatic push_until(input int k, input bit ordy);
        bit a;
        int t;
        a = 0;
        for (t = 0; t < 20 && !a; t++) step(k, 1, 0, ordy, a);
        chk("push_bound", 128'(a), 128'(1));
    endtask

    initial begin
        bit a;
        int n;
        kt[0]  = mk(32'h91000421, 4'd0, 3'd2, 2'd0, 8'b1001_0000, 0);
        kt[1]  = mk({11'b10001011000, 5'd3, 6'd0, 5'd2, 5'd1}, 4'd0, 3'd2, 2'd0, 8'b1000_0000, 0);
        kt[2]  = mk({11'b10101011000, 5'd4, 6'd0, 5'd5, 5'd6}, 4'd0, 3'd2, 2'd0, 8'b1000_1000, 0);
        kt[3]  = mk({11'b11001011000, 5'd7, 6'd0, 5'd8, 5'd9}, 4'd0, 3'd3, 2'd0, 8'b1000_0000, 0);
        kt[4]  = mk({11'b11101011000, 5'd1, 6'd0, 5'd2, 5'd3}, 4'd0, 3'd3, 2'd0, 8'b1000_1000, 0);
        kt[5]  = mk({11'b10001010000, 5'd2, 6'd0, 5'd3, 5'd4}, 4'd0, 3'd4, 2'd0, 8'b1000_0000, 0);
        kt[6]  = mk({11'b10101010000, 5'd3, 6'd0, 5'd4, 5'd5}, 4'd0, 3'd5, 2'd0, 8'b1000_0000, 0);
        kt[7]  = mk({11'b11001010000, 5'd4, 6'd0, 5'd5, 5'd6}, 4'd0, 3'd6, 2'd0, 8'b1000_0000, 0);
        kt[8]  = mk({11'b11010011010, 5'd0, 6'd3, 5'd6, 5'd7}, 4'd0, 3'd0, 2'd1, 8'b1000_0000, 0);
        kt[9]  = mk({11'b11010011011, 5'd0, 6'd5, 5'd7, 5'd8}, 4'd0, 3'd0, 2'd1, 8'b1000_0100, 0);
        kt[10] = mk({11'b10011011000, 5'd9, 6'd0, 5'd8, 5'd7}, 4'd0, 3'd0, 2'd2, 8'b1000_0000, 0);
        kt[11] = mk({11'b10011010110, 5'd1, 6'd3, 5'd9, 5'd2}, 4'd0, 3'd0, 2'd3, 8'b1000_0000, 0);
        kt[12] = mk({11'b11111000010, 9'd16, 2'd0, 5'd10, 5'd11}, 4'd0, 3'd2, 2'd0, 8'b1011_0000, 0);
        kt[13] = mk({11'b11111000000, 9'd8, 2'd0, 5'd12, 5'd13}, 4'd1, 3'd2, 2'd0, 8'b0101_0000, 0);
        kt[14] = mk(32'h14000010, 4'd8, 3'd0, 2'd0, 8'b0000_0010, 0);
        kt[15] = mk({6'b100101, 26'h0000123}, 4'd7, 3'd0, 2'd0, 8'b1000_0010, 1);
        kt[16] = mk({8'b10110100, 19'd7, 5'd4}, 4'd5, 3'd0, 2'd0, 8'b0000_0010, 0);
        kt[17] = mk({8'b01010100, 19'd3, 5'd1}, 4'd3, 3'd0, 2'd0, 8'b0000_0010, 0);
        kt[18] = mk({11'b11010110000, 5'd31, 6'd0, 5'd7, 5'd0}, 4'd6, 3'd0, 2'd0, 8'b0000_0010, 0);
        kt[19] = mk(32'h00000000, 4'd0, 3'd0, 2'd0, 8'b0000_0001, 0);

        reset_n = 1'b0;
        dq.in_valid = 1'b0; dq.in_instr = '0; dq.in_pc = '0; dq.flush = 1'b0; dq.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step(K_ADD, 0, 0, 0, a);

        step(K_ADDI, 1, 0, 0, a);
        step(K_ADD, 0, 0, 0, a);
        step(K_ADD, 0, 0, 1, a);
        drain();

        for (int i = 0; i < 8; i++) step(K_ADD, 1, 0, 0, a);
        step(K_ADD, 1, 0, 0, a);
        chk("full_hold", 128'(a), 128'(0));
        step(K_ADD, 1, 0, 1, a);
        chk("full_pop_same_cycle", 128'(a), 128'(0));
        step(K_ADD, 1, 0, 0, a);
        chk("full_reopen", 128'(a), 128'(1));
        drain();

        for (int i = 0; i < 4; i++) step(K_B, 1, 0, 0, a);
        step(K_B, 1, 0, 0, a);
        chk("br_cap_hold", 128'(a), 128'(0));
        step(K_ADD, 1, 0, 0, a);
        chk("br_cap_add", 128'(a), 128'(1));
        step(K_B, 1, 0, 1, a);
        step(K_B, 1, 0, 0, a);
        chk("br_cap_reopen", 128'(a), 128'(1));
        drain();

        step(K_ADD, 1, 0, 0, a);
        step(K_B, 1, 0, 0, a);
        step(K_CBZ, 1, 0, 0, a);
        step(K_LDUR, 1, 0, 0, a);
        step(K_STUR, 1, 0, 0, a);
        step(K_ADD, 1, 1, 1, a);
        step(K_ADD, 0, 0, 1, a);
        step(K_BL, 1, 0, 0, a);
        drain();

        for (int k = 0; k < NK; k++) push_until(k, 1'b1);
        drain();
        push_until(K_LSL, 1'b0);
        push_until(K_DIV, 1'b0);
        push_until(K_ILL, 1'b0);
        push_until(K_BL, 1'b0);
        drain();

        n = 0;
        for (int i = 0; i < 2000 && n < 70; i++) begin
            step(int'($urandom_range(0, NK - 1)), 1, 0, bit'($urandom_range(0, 1)), a);
            n += int'(a);
        end
        chk("stream_count", 128'(n), 128'(70));
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/decode_queue_ooo.md
# decode_queue_ooo

Registered LEGv8 decode stage with a parametrised micro-op queue, between fetch and rename/dispatch in the out-of-order core. Each accepted instruction is decoded into a control record and written into a DEPTH-entry FIFO together with its PC and a sequence tag. The FIFO presents the head entry with valid/ready flow control. The block also supports pipeline flush and a cap on the number of queued control-transfer instructions.

## Interface
- DEPTH, 8: queue entries; power of two, minimum 2.
- PC_W, 64: PC width.
- SEQ_W, 6: sequence-tag width; the tag wraps modulo 2^SEQ_W.
- MAX_BR, 4: maximum number of queued entries with is_branch=1; range 1..DEPTH.
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue accepts the instruction this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  instruction PC.
- flush  in  1  discard all queued entries.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer takes the head entry.
- out_pc  out  PC_W  head PC.
- out_seq  out  SEQ_W  head sequence tag.
- out_rd, out_rn, out_rm  out  5 each  instr[4:0], [9:5], [20:16]; out_rd is forced to 30 for BL.
- out_imm  out  26  raw immediate bits instr[25:0].
- out_cmd_type  out  4  0=ALU/LDUR/illegal, 1=STUR, 3=B.cond, 5=CBZ, 6=BR, 7=BL, 8=B.
- out_alu_op  out  3  2=add, 3=sub, 4=and, 5=orr, 6=eor, 0 otherwise.
- out_which_math  out  2  0=ALU, 1=shift, 2=mul, 3=div.
- out_ctrl  out  8  control bits {reg_write, mem_write, mem_to_reg, alu_src, save_cond, left_shift, is_branch, illegal}, bit 7 first.
- br_count  out  $clog2(MAX_BR+1)  number of queued branch entries.

## Operation
- Decode is combinational on in_instr. Only the decoded record is stored; no field is ever X.
- ALU group, all with reg_write=1:
  - ADDI [31:22]=1001000100: alu_op=2, alu_src=1.
  - ADD 10001011000: alu_op=2.
  - ADDS 10101011000: alu_op=2, save_cond=1.
  - SUB 11001011000: alu_op=3.
  - SUBS 11101011000: alu_op=3, save_cond=1.
  - AND 10001010000: alu_op=4.
  - ORR 10101010000: alu_op=5.
  - EOR 11001010000: alu_op=6.
- Shift, multiply and divide, all with reg_write=1:
  - LSR 11010011010: which_math=1, left_shift=0.
  - LSL 11010011011: which_math=1, left_shift=1.
  - MUL 10011011000: which_math=2.
  - DIV 10011010110: which_math=3.
- Memory, both with alu_op=2 and alu_src=1:
  - LDUR 11111000010: reg_write=1, mem_to_reg=1.
  - STUR 11111000000: mem_write=1.
- Branches, all with is_branch=1 and reg_write=0 unless stated:
  - B [31:26]=000101.
  - BL 100101: reg_write=1, rd=30.
  - CBZ [31:24]=10110100.
  - B.cond 01010100.
  - BR 11010110000.
- Anything else decodes to illegal=1 with all other control bits 0. An illegal instruction is still queued so that rename can raise the exception.
- Push: in_valid & in_ready & ~flush. The entry is written at the tail with seq = seq_ctr, then seq_ctr increments.
- Pop: out_valid & out_ready & ~flush. The head advances.
- in_ready = (count < DEPTH) & ~(dec_is_branch & br_count == MAX_BR). in_ready depends combinationally on in_instr and never on out_ready.
- Push and pop in the same cycle: count is unchanged; br_count is adjusted by both the pushed and the popped entries.
- Flush: count, head, tail and br_count go to 0 at the next edge. Any push or pop in that cycle is ignored. seq_ctr is not reset, so tags stay monotonic across a flush.
- seq_ctr wraps from 2^SEQ_W-1 to 0. Pointers wrap modulo DEPTH.

## Timing
- Reset (reset_n=0 at a rising edge) gives count=0, head=tail=0, seq_ctr=0, br_count=0, out_valid=0 and in_ready=1.
- All out_* fields read as 0 while out_valid=0, both after reset and after a flush.
- Latency: an instruction pushed at edge N is visible on out_* after edge N, i.e. in cycle N+1, when the queue was empty. There is no combinational bypass from input to output.
- out_* fields are held stable while out_valid=1 and out_ready=0.
- Full: in_ready=0. A pop at a full edge re-opens in_ready in the following cycle, not in the same cycle.
- Reset has priority over flush, and flush has priority over push and pop.

## Test plan
- Reset then push ADDI: drive 0x91000421 at edge 1. Expect out_valid=1 in the next cycle with cmd_type=0, alu_op=2, ctrl=8'b1001_0000, rd=1, rn=1 and seq=0.
- Fill to full: push DEPTH (8) ADDs with out_ready=0. Expect in_ready=0 after the 8th push and the 9th input held. Then pop one and expect in_ready=1 in the next cycle, and the 9th entry to carry seq=8.
- Branch cap: push 4 B instructions (0x14000010). Expect br_count=4, a 5th B held off (in_ready=0) while an ADD is still accepted. Pop one B and expect the held B to be accepted.
- Flush mid-stream: with 5 entries queued, assert flush together with in_valid and out_ready. Expect out_valid=0, br_count=0 and no pop observed. The next push gets seq=6 if 6 entries had been pushed before.
- Decode sweep: push one instance of each listed opcode plus 0x00000000. Expect BL rd=30 with reg_write=1, LSL left_shift=1, DIV which_math=3, and 0x0 giving illegal=1 with all other ctrl bits 0.
- Seq wrap and back-pressure: stream 70 entries with random out_ready. Expect the tags to run 0..63 then 0..5, PCs in order, and no entry lost or duplicated.
